twobit_counter: RTL and testbench

TWOBIT_COUNTER -- requirements
Module: twobit_counter

---
 rtl/twobit_counter_pkg.sv | 25 ++
 rtl/twobit_counter_prescaler.sv | 39 +++
 rtl/twobit_counter.sv | 58 +++++
 tb/tb_twobit_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/twobit_counter_pkg.sv
// Shared constants for the two-bit digit-select counter and its prescaler.
// Holds the default step divisor, the counter width and the active-low anode codes.
package twobit_counter_pkg;

    localparam int DEFAULT_DIV = 1;
    localparam int CNT_W       = 2;

    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;

    function automatic logic [3:0] an_decode(input logic [CNT_W-1:0] v);
        logic [3:0] an;
        an = AN_0;
        unique case (v)
            2'd0: an = AN_0;
            2'd1: an = AN_1;
            2'd2: an = AN_2;
            2'd3: an = AN_3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/twobit_counter_prescaler.sv
// Enable-gated modulo-DIV prescaler; tick is high on the enabled clock that
// completes a DIV-cycle period.
module twobit_counter_prescaler
    import twobit_counter_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic          w_last;

    assign w_last = (r_pre == LAST);
    assign tick   = en && w_last;

    // With DIV=1 LAST is 0, so the count never leaves 0 and every enabled clock ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            if (w_last)
                r_pre <= '0;
            else
                r_pre <= r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/twobit_counter.sv
// Two-bit up/down digit-select counter with prescaled stepping, synchronous
// clear, registered wrap pulse and active-low one-hot anode decode.
module twobit_counter
    import twobit_counter_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    output logic [CNT_W-1:0] r,
    output logic [3:0]       an,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             w_tick;

    twobit_counter_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .tick  (w_tick)
    );

    // Clear wins over a coincident step and never raises wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            if (up) begin
                r_cnt  <= r_cnt + 2'd1;
                r_wrap <= (r_cnt == 2'd3);
            end else begin
                r_cnt  <= r_cnt - 2'd1;
                r_wrap <= (r_cnt == 2'd0);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign r    = r_cnt;
    assign wrap = r_wrap;
    assign an   = an_decode(r_cnt);

endmodule

// File: tb/tb_twobit_counter.sv
// Bench for twobit_counter: a DIV=1 and a DIV=4 instance share stimulus and are
// compared every cycle against an arithmetic model of the counting rules.
module tb_twobit_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, clr;
    logic [1:0] r1, r4;
    logic [3:0] an1, an4;
    logic       wrap1, wrap4;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: index 0 is the DIV=1 instance, index 1 the DIV=4 instance.
    int m_r[2];
    int m_ecnt[2];
    int m_wrap[2];
    int m_div[2] = '{1, 4};

    always #5 clk = ~clk;

    twobit_counter #(.DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
        .r(r1), .an(an1), .wrap(wrap1)
    );

    twobit_counter #(.DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
        .r(r4), .an(an4), .wrap(wrap4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_r[k] = 0; m_ecnt[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // A step happens on every DIV-th enabled clock since the last clear/reset.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                m_r[k] = 0; m_ecnt[k] = 0; m_wrap[k] = 0;
            end else if (en) begin
                m_ecnt[k] = m_ecnt[k] + 1;
                if (m_ecnt[k] % m_div[k] == 0) begin
                    m_wrap[k] = up ? (m_r[k] == 3) : (m_r[k] == 0);
                    m_r[k]    = up ? (m_r[k] + 1) % 4 : (m_r[k] + 3) % 4;
                end else begin
                    m_wrap[k] = 0;
                end
            end else begin
                m_wrap[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".r1"},    int'(r1),    m_r[0]);
        chk({tag, ".an1"},   int'(an1),   int'(~(4'b0001 << m_r[0]) & 4'hF));
        chk({tag, ".wrap1"}, int'(wrap1), m_wrap[0]);
        chk({tag, ".r4"},    int'(r4),    m_r[1]);
        chk({tag, ".an4"},   int'(an4),   int'(~(4'b0001 << m_r[1]) & 4'hF));
        chk({tag, ".wrap4"}, int'(wrap4), m_wrap[1]);
        chk({tag, ".an1_onehot0"}, $countones(~an1), 1);
    endtask

    task automatic cyc(input logic e, input logic u, input logic c, input string tag);
        en = e; up = u; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int exp_up[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        int guard;
        int cnt_before;

        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
        model_reset();
        #2;
        check_all("reset0");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Up-count with constant expectations for the DIV=1 instance.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, "up");
            chk("up_seq.r1", int'(r1), exp_up[i]);
            chk("up_seq.wrap1", int'(wrap1), (exp_up[i] == 0) ? 1 : 0);
        end

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, "down");
        chk("down_end.r1", int'(r1), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, "hold");

        // Asynchronous reset in the middle of a clock period.
        cyc(1, 1, 0, "pre_rst");
        cyc(1, 1, 0, "pre_rst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.r1", int'(r1), 0);
        chk("async_rst.an1", int'(an1), 4'b1110);
        chk("async_rst.wrap1", int'(wrap1), 0);
        chk("async_rst.r4", int'(r4), 0);
        cyc(1, 1, 0, "in_rst");
        rst_n = 1'b1;

        // DIV=4 stepping, with a 2-clock enable gap mid-period.
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, "pres");
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, "pres_gap");
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, "pres");

        // Park DIV=4 at r=3 with a step due on the next enabled clock.
        guard = 0;
        while (!(m_r[1] == 3 && m_ecnt[1] % 4 == 3) && guard < 64) begin
            cyc(1, 1, 0, "to_clr");
            guard++;
        end
        chk("clr_setup_in_time", (guard < 64) ? 1 : 0, 1);
        cyc(1, 1, 1, "clr");
        chk("clr.r4", int'(r4), 0);
        chk("clr.wrap4", int'(wrap4), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, "post_clr");
            chk("post_clr_hold.r4", int'(r4), 0);
        end
        cyc(1, 1, 0, "post_clr");
        chk("post_clr_step.r4", int'(r4), 1);

        // Random traffic, including one asynchronous reset.
        cnt_before = n_cmp;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("rand_rst.r4", int'(r4), 0);
                chk("rand_rst.an4", int'(an4), 4'b1110);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 3) != 0), 1'($urandom % 2),
                ($urandom_range(0, 19) == 0), "rand");
        end
        chk("rand_ran", (n_cmp > cnt_before) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
